// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-to-decode handshake bundle for the prefetch queue.
// master = fetch/decode side driver, slave = the queue itself.
interface fetch_queue_if #(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = $clog2(DEPTH) + 1
);
    logic                 flush;
    logic                 inValid;
    logic [WORD_SIZE-1:0] inPC;
    logic [WORD_SIZE-1:0] inInstruction;
    logic                 inReady;
    logic                 outValid;
    logic [WORD_SIZE-1:0] outPC;
    logic [WORD_SIZE-1:0] outInstruction;
    logic                 outReady;
    logic [CNT_W-1:0]     count;

    modport master (
        output flush,
        output inValid,
        output inPC,
        output inInstruction,
        output outReady,
        input  inReady,
        input  outValid,
        input  outPC,
        input  outInstruction,
        input  count
    );

    modport slave (
        input  flush,
        input  inValid,
        input  inPC,
        input  inInstruction,
        input  outReady,
        output inReady,
        output outValid,
        output outPC,
        output outInstruction,
        output count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular prefetch FIFO of {PC, instruction} between fetch and decode.
// Optional FETCH_QUEUE_BYPASS_EN: empty-queue input drives outputs combinationally.
module fetch_queue #(
    parameter int WORD_SIZE = 32,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input logic         clk,
    input logic         rst,
    fetch_queue_if.slave q_if
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WORD_SIZE-1:0] pcMem_q  [DEPTH];
    logic [WORD_SIZE-1:0] insMem_q [DEPTH];

    logic [AW-1:0]    rdPtr_q;
    logic [AW-1:0]    rdPtr_d;
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    wrPtr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic empty;
    logic full;
    logic headValid;
    logic enq;
    logic deq;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // inReady depends only on the registered count, never on outReady
    assign q_if.inReady = ~full;
    assign q_if.count   = count_q;
    assign q_if.outValid = headValid;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    // rst gate keeps outputs quiet while reset is held
    assign bypass = empty & q_if.inValid & ~q_if.flush & rst;

    assign headValid = (~empty & ~q_if.flush) | bypass;
    assign deq = ~empty & ~q_if.flush & q_if.outReady;
    // a bypassed pair consumed the same cycle is never written
    assign enq = q_if.inValid & ~full & ~q_if.flush
               & ~(bypass & q_if.outReady);
`else
    assign headValid = ~empty & ~q_if.flush;
    assign deq = headValid & q_if.outReady;
    assign enq = q_if.inValid & ~full & ~q_if.flush;
`endif

    // Head presentation: zero whenever nothing valid is offered
    always_comb begin
        q_if.outPC          = '0;
        q_if.outInstruction = '0;
        if (headValid) begin
            q_if.outPC          = pcMem_q[rdPtr_q];
            q_if.outInstruction = insMem_q[rdPtr_q];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass) begin
            q_if.outPC          = q_if.inPC;
            q_if.outInstruction = q_if.inInstruction;
        end
`endif
    end

    // Next pointers and occupancy; pointers wrap modulo DEPTH
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        if (deq) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        if (enq) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
    end

    // Control state: reset dominates flush, flush drops same-cycle traffic
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else if (q_if.flush) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (enq) begin
            pcMem_q[wrPtr_q]  <= q_if.inPC;
            insMem_q[wrPtr_q] <= q_if.inInstruction;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue.
// Expected pairs are queued on accepted enqueues and compared at the head.
module tb_fetch_queue;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    typedef logic [2*W-1:0] pair_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_queue_if #(.WORD_SIZE(W), .DEPTH(D), .CNT_W(CW)) bus ();

    fetch_queue #(.WORD_SIZE(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst  (rst),
        .q_if (bus)
    );

    pair_t sb[$];
    int    vectors     = 0;
    int    miscompares = 0;
    bit    armed       = 1'b0;
    int    szPre;
    bit    bypTaken;
    bit    expOv;
    pair_t head;
    logic [W-1:0] pcCnt;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model update at each active edge
    always @(posedge clk) begin
        armed = 1'b1;
        if (!rst || bus.flush) begin
            sb.delete();
        end else begin
            szPre    = sb.size();
            bypTaken = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
            bypTaken = (szPre == 0) && bus.inValid && bus.outReady;
`endif
            if (!bypTaken) begin
                if (szPre != 0 && bus.outReady) begin
                    void'(sb.pop_front());
                end
                if (bus.inValid && szPre != D) begin
                    sb.push_back({bus.inPC, bus.inInstruction});
                end
            end
        end
    end

    // Output checks away from the active edge
    always @(negedge clk) begin
        if (armed) begin
            expOv = !bus.flush && (sb.size() != 0);
`ifdef FETCH_QUEUE_BYPASS_EN
            expOv = expOv || (rst && !bus.flush && sb.size() == 0
                              && bus.inValid);
`endif
            head = (sb.size() != 0) ? sb[0]
                                    : {bus.inPC, bus.inInstruction};
            check_eq("count", 64'(bus.count), 64'(sb.size()));
            check_eq("inReady", 64'(bus.inReady), 64'(sb.size() != D));
            check_eq("outValid", 64'(bus.outValid), 64'(expOv));
            check_eq("outPC", 64'(bus.outPC),
                     expOv ? 64'(head[2*W-1:W]) : 64'd0);
            check_eq("outInstruction", 64'(bus.outInstruction),
                     expOv ? 64'(head[W-1:0]) : 64'd0);
        end
    end

    task automatic cyc(input bit iv, input logic [W-1:0] pc,
                       input bit ordy, input bit fl);
        bus.inValid       = iv;
        bus.inPC          = pc;
        bus.inInstruction = $urandom;
        bus.outReady      = ordy;
        bus.flush         = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        // reset held two cycles with traffic offered
        cyc(1, 32'h200, 1, 0);
        cyc(1, 32'h204, 1, 0);
        rst = 1'b1;

        // fill to full, fifth pair refused, then drain
        for (int i = 0; i < 5; i++) cyc(1, W'(i * 4), 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 32'h0, 1, 0);

        // streaming with pointer wrap
        for (int i = 0; i < 10; i++) cyc(1, W'(i * 4), 1, 0);
        for (int i = 0; i < 2; i++) cyc(0, 32'h0, 1, 0);

        // flush with enqueue and dequeue requested
        for (int i = 0; i < 3; i++) cyc(1, W'(32'h50 + i * 4), 0, 0);
        cyc(1, 32'h40, 1, 1);
        cyc(1, 32'h80, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 1, 0);

        // full with simultaneous dequeue
        for (int i = 0; i < 4; i++) cyc(1, W'(32'h900 + i * 4), 0, 0);
        cyc(1, 32'h99c, 1, 0);
        cyc(1, 32'h9a0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 32'h0, 1, 0);

        // reset mid-operation dominates flush
        for (int i = 0; i < 2; i++) cyc(1, W'(32'ha00 + i * 4), 0, 0);
        rst = 1'b0;
        cyc(1, 32'hbad0, 1, 1);
        rst = 1'b1;
        cyc(1, 32'hc00, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 1, 0);

        // randomized traffic
        pcCnt = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, pcCnt,
                $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
            pcCnt = pcCnt + 32'd4;
        end
        for (int i = 0; i < D + 2; i++) cyc(0, 32'h0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue sitting directly downstream of the instruction-fetch stage and upstream of the instruction-decode stage. Captures `{PC, instruction}` pairs produced by fetch into a small circular FIFO and presents them in order to decode. Decouples fetch from decode stalls; its `inReady` drives fetch's freeze as `~inReady`. Flushes all held entries on a taken branch.

## Interface
- `WORD_SIZE`, 32, width of PC and instruction words
- `DEPTH`, 4, number of entries; power of two, minimum 2
- `CNT_W`, `$clog2(DEPTH)+1`, width of occupancy count

- `clk`  input  1  rising-edge clock; only clock
- `rst`  input  1  synchronous, active-low reset; sampled on `clk` rising edge
- `flush`  input  1  discard all entries (driven by branch-taken)
- `inValid`  input  1  fetch presents a valid pair this cycle
- `inPC`  input  WORD_SIZE  PC of fetched instruction
- `inInstruction`  input  WORD_SIZE  fetched instruction
- `inReady`  output  1  queue accepts an entry this cycle
- `outValid`  output  1  head entry valid for decode
- `outPC`  output  WORD_SIZE  head PC
- `outInstruction`  output  WORD_SIZE  head instruction
- `outReady`  input  1  decode consumes head this cycle (`~freeze` of decode)
- `count`  output  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage: `DEPTH`-entry array, read pointer `rdPtr`, write pointer `wrPtr` (each `$clog2(DEPTH)` bits, wrap modulo DEPTH naturally), `count` register.
- Enqueue fires when `inValid & inReady & ~flush`: write pair at `wrPtr`, `wrPtr` += 1.
- Dequeue fires when `outValid & outReady & ~flush`: `rdPtr` += 1.
- `count` next = count + enq − deq; simultaneous enq and deq leaves count unchanged.
- `inReady = (count != DEPTH)`; combinational from registered count only (no dependence on `outReady`). Full queue with same-cycle dequeue still refuses enqueue.
- `outValid = (count != 0) & ~flush` (bypass case: see Configuration).
- `outPC`/`outInstruction` = entry at `rdPtr` when `outValid`, else all zero.
- Flush: highest priority after reset. On a rising edge with `flush`=1: `rdPtr`=`wrPtr`=0, `count`=0; same-cycle enqueue and dequeue are dropped. While `flush`=1, `outValid`=0.
- Reset (`rst`=0 at edge): pointers 0, count 0, array contents don't-care. Reset mid-operation discards all entries; reset dominates flush.

## Timing
- Reset values: `count`=0, `outValid`=0, `outPC`=0, `outInstruction`=0, `inReady`=1.
- Latency (no bypass): entry enqueued at edge N is visible on `outValid`/outputs after edge N, i.e. consumable in cycle N+1.
- Throughput: one enqueue and one dequeue per cycle sustained when 0 < count < DEPTH.
- Full: `count`=DEPTH → `inReady`=0; first cycle after a dequeue edge, `inReady`=1.
- Empty: `outValid`=0, outputs zero; `outReady` ignored.
- Pointer wrap: after DEPTH enqueues `wrPtr` returns to 0; order preserved across wrap.
- Entry after flush: enqueue in cycle following flush is accepted normally (`inReady`=1).

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when `count`=0 and `inValid`=1 and `~flush`, input pair drives outputs combinationally with `outValid`=1. If `outReady`=1 that cycle, pair is consumed directly: no write, count stays 0. If `outReady`=0, pair is written normally. Zero-cycle latency through an empty queue.
- Not defined: no combinational path from `in*` to `out*`; one-cycle minimum latency as in Timing.

## Test plan
- Reset: hold `rst`=0 two cycles with `inValid`=1 → `count`=0, `outValid`=0, `inReady`=1, outputs 0; release → normal enqueue next edge.
- Fill/drain, DEPTH=4, `outReady`=0: enqueue PCs 0x0,0x4,0x8,0xC → `count`=4, `inReady`=0, fifth pair (0x10) not accepted; then `outReady`=1 → outputs 0x0,0x4,0x8,0xC on consecutive cycles, then `outValid`=0.
- Streaming with wrap: `inValid`=`outReady`=1 for 10 cycles, PCs 0x0..0x24 → each PC appears once in order, one cycle after enqueue (no bypass), `count` steady at ≤1, pointers wrap twice.
- Flush: count=3, assert `flush` with `inValid`=1 (PC 0x40) and `outReady`=1 → `outValid`=0 that cycle, next cycle `count`=0, 0x40 not stored; next enqueue 0x80 emerges as sole entry.
- Full with simultaneous dequeue: count=4, `inValid`=1, `outReady`=1 → head dequeued, incoming rejected, `count`=3, `inReady`=1 next cycle.
- Bypass (macro defined): empty, `inValid`=1 PC 0x100, `outReady`=1 → same-cycle `outValid`=1, `outPC`=0x100, `count` stays 0; with `outReady`=0 → `count`=1 after edge.
